lcd_responder: RTL and testbench

Cycle-accurate, synthesizable model of the HD44780-style character LCD controller at the receiving end of the EN/RS/RW/data bus that the LCD writer drives. It decodes commands and data on each EN falling edge, keeps a 2x16 DDRAM image, the address counter and the mode flags, and emulates the busy flag. The testbench uses it to check displayed text directly. The FPGA top can also instantiate it as an on-chip mirror of the panel.

---
 rtl/lcd_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_lcd_responder.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_responder.sv
// lcd_responder: HD44780-style character LCD receiver that decodes the
// EN/RS/RW/data bus and holds a 2x16 DDRAM image.
// Ports:
//   clk, rst                 clock and async active-high reset
//   EN, RW, RS, data[15:0]   writer bus; sampled on the EN falling edge
//   data_out[7:0]            read data, {busy, ac} on status read
//   rd_addr[4:0], rd_char    character probe (0-15 line 1, 16-31 line 2)
//   ac, busy                 address counter and busy flag
//   display_on, cursor_on,
//   blink_on, two_line,
//   entry_inc, entry_shift   mode flags
//   bad_cmd, overrun         sticky error flags
module lcd_responder #(
  parameter int BUSY_CYCLES  = 2000,
  parameter int CLEAR_CYCLES = 76500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EN,
  input  logic        RW,
  input  logic        RS,
  input  logic [15:0] data,
  output logic [7:0]  data_out,
  input  logic [4:0]  rd_addr,
  output logic [7:0]  rd_char,
  output logic [6:0]  ac,
  output logic        busy,
  output logic        display_on,
  output logic        cursor_on,
  output logic        blink_on,
  output logic        two_line,
  output logic        entry_inc,
  output logic        entry_shift,
  output logic        bad_cmd,
  output logic        overrun
);

  localparam int MAX_CYC =
    (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] BUSY_LD  = CW'(BUSY_CYCLES);
  localparam logic [CW-1:0] CLEAR_LD = CW'(CLEAR_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_FILL = 1'b1;

  localparam logic [7:0] SPACE = 8'h20;

  // Cursor step with the 0x0F<->0x40 and 0x4F<->0x00 line wraps.
  function automatic logic [6:0] ac_step(
    input logic [6:0] a,
    input logic       up
  );
    logic [6:0] r;
    if (up) begin
      if (a == 7'h0F)      r = 7'h40;
      else if (a == 7'h4F) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h4F;
      else if (a == 7'h40) r = 7'h0F;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  logic          en_q;
  logic [0:0]    state_q, state_d;
  logic [4:0]    fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [6:0]    ac_q, ac_d;
  logic [7:0]    mem_q [32];
  logic [7:0]    mem_d [32];
  logic [7:0]    dout_q, dout_d;
  logic          disp_q, disp_d;
  logic          cur_q, cur_d;
  logic          blink_q, blink_d;
  logic          two_q, two_d;
  logic          inc_q, inc_d;
  logic          shift_q, shift_d;
  logic          bad_q, bad_d;
  logic          over_q, over_d;

  logic          strobe;
  logic          wr_stb;
  logic          rd_stb;
  logic          busy_now;
  logic [7:0]    din;
  logic [4:0]    ac_idx;
  logic [6:0]    ac_next;
  logic          unused_hi;

  assign unused_hi = ^data[15:8];

  always_comb begin
    strobe   = en_q & ~EN;
    wr_stb   = strobe & ~RW;
    rd_stb   = strobe & RW;
    din      = data[7:0];
    busy_now = (cnt_q != '0);
    // Cell index: line bit from ac[6], column from ac[3:0].
    ac_idx   = {ac_q[6], ac_q[3:0]};
    ac_next  = ac_step(ac_q, inc_q);
  end

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    cnt_d   = busy_now ? cnt_q - 1'b1 : '0;
    ac_d    = ac_q;
    mem_d   = mem_q;
    disp_d  = disp_q;
    cur_d   = cur_q;
    blink_d = blink_q;
    two_d   = two_q;
    inc_d   = inc_q;
    shift_d = shift_q;
    bad_d   = bad_q;
    over_d  = over_q;

    if (state_q == S_FILL) begin
      mem_d[fill_q] = SPACE;
      fill_d        = fill_q + 5'd1;
      if (fill_q == 5'd31) state_d = S_IDLE;
    end

    if (wr_stb && busy_now) begin
      // Dropped write; the running busy time is left untouched.
      over_d = 1'b1;
    end else if (wr_stb && RS) begin
      mem_d[ac_idx] = din;
      ac_d          = ac_next;
      cnt_d         = BUSY_LD;
    end else if (wr_stb) begin
      if (din != 8'h00) cnt_d = BUSY_LD;
      priority case (1'b1)
        din[7]: begin
          if (din[5:4] == 2'b00) ac_d = din[6:0];
          else                   bad_d = 1'b1;
        end
        din[6]: bad_d = 1'b1;
        din[5]: two_d = din[3];
        din[4]: begin
          if (!din[3]) ac_d = ac_step(ac_q, din[2]);
        end
        din[3]: begin
          disp_d  = din[2];
          cur_d   = din[1];
          blink_d = din[0];
        end
        din[2]: begin
          inc_d   = din[1];
          shift_d = din[0];
        end
        din[1]: ac_d = 7'h00;
        din[0]: begin
          ac_d    = 7'h00;
          inc_d   = 1'b1;
          state_d = S_FILL;
          fill_d  = 5'd0;
          cnt_d   = CLEAR_LD;
        end
        default: ;
      endcase
    end

    if (rd_stb && RS) ac_d = ac_next;

    dout_d = 8'h00;
    if (EN && RW) begin
      if (RS) dout_d = mem_q[ac_idx];
      else    dout_d = {busy_now, ac_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b0;
      state_q <= S_IDLE;
      fill_q  <= 5'd0;
      cnt_q   <= '0;
      ac_q    <= 7'h00;
      for (int i = 0; i < 32; i++) mem_q[i] <= SPACE;
      dout_q  <= 8'h00;
      disp_q  <= 1'b0;
      cur_q   <= 1'b0;
      blink_q <= 1'b0;
      two_q   <= 1'b0;
      inc_q   <= 1'b1;
      shift_q <= 1'b0;
      bad_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      en_q    <= EN;
      state_q <= state_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      ac_q    <= ac_d;
      mem_q   <= mem_d;
      dout_q  <= dout_d;
      disp_q  <= disp_d;
      cur_q   <= cur_d;
      blink_q <= blink_d;
      two_q   <= two_d;
      inc_q   <= inc_d;
      shift_q <= shift_d;
      bad_q   <= bad_d;
      over_q  <= over_d;
    end
  end

  assign data_out    = dout_q;
  assign rd_char     = mem_q[rd_addr];
  assign ac          = ac_q;
  assign busy        = busy_now;
  assign display_on  = disp_q;
  assign cursor_on   = cur_q;
  assign blink_on    = blink_q;
  assign two_line    = two_q;
  assign entry_inc   = inc_q;
  assign entry_shift = shift_q;
  assign bad_cmd     = bad_q;
  assign overrun     = over_q;

endmodule

// File: tb/tb_lcd_responder.sv
// tb_lcd_responder: randomized self-checking bench for lcd_responder
// against a position-based model of the 32-character display.
module tb_lcd_responder;

  localparam int BC = 20;
  localparam int CC = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        EN;
  logic        RW;
  logic        RS;
  logic [15:0] data;
  logic [7:0]  data_out;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_char;
  logic [6:0]  ac;
  logic        busy;
  logic        display_on;
  logic        cursor_on;
  logic        blink_on;
  logic        two_line;
  logic        entry_inc;
  logic        entry_shift;
  logic        bad_cmd;
  logic        overrun;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int busy_end = 0;

  logic [7:0] m_cells [32];
  logic [6:0] m_ac;
  logic m_inc, m_shift, m_disp, m_cur, m_blink, m_two, m_bad, m_over;
  logic [7:0] last_rd;
  logic [7:0] last_st;

  lcd_responder #(.BUSY_CYCLES(BC), .CLEAR_CYCLES(CC)) dut (
    .clk(clk), .rst(rst), .EN(EN), .RW(RW), .RS(RS), .data(data),
    .data_out(data_out), .rd_addr(rd_addr), .rd_char(rd_char),
    .ac(ac), .busy(busy), .display_on(display_on),
    .cursor_on(cursor_on), .blink_on(blink_on), .two_line(two_line),
    .entry_inc(entry_inc), .entry_shift(entry_shift),
    .bad_cmd(bad_cmd), .overrun(overrun)
  );

  always #50 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pos_of(input logic [6:0] a);
    return (a >= 7'h40) ? int'(a) - 64 + 16 : int'(a);
  endfunction

  function automatic logic [6:0] addr_of(input int p);
    return (p < 16) ? 7'(p) : 7'(p - 16 + 64);
  endfunction

  task automatic m_move(input logic up);
    m_ac = addr_of((pos_of(m_ac) + (up ? 1 : 31)) % 32);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
    m_ac = 0; m_inc = 1; m_shift = 0; m_disp = 0; m_cur = 0;
    m_blink = 0; m_two = 0; m_bad = 0; m_over = 0;
    busy_end = 0;
  endtask

  task automatic model_apply(input logic rs, input logic rw,
                             input logic [7:0] d, input logic bb,
                             input int s);
    int a;
    if (!rw) begin
      if (bb) m_over = 1;
      else if (rs) begin
        m_cells[pos_of(m_ac)] = d;
        m_move(m_inc);
        busy_end = s + BC;
      end else if (d != 0) begin
        busy_end = s + BC;
        if (d >= 8'h80) begin
          a = int'(d) - 128;
          if (a <= 15 || (a >= 64 && a <= 79)) m_ac = 7'(a);
          else m_bad = 1;
        end else if (d >= 8'h40) m_bad = 1;
        else if (d >= 8'h20) m_two = d[3];
        else if (d >= 8'h10) begin
          if (!d[3]) m_move(d[2]);
        end else if (d >= 8'h08) begin
          m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
        end else if (d >= 8'h04) begin
          m_inc = d[1]; m_shift = d[0];
        end else if (d >= 8'h02) m_ac = 0;
        else begin
          m_ac = 0; m_inc = 1;
          for (int i = 0; i < 32; i++) m_cells[i] = 8'h20;
          busy_end = s + CC;
        end
      end
    end else if (rs) m_move(m_inc);
  endtask

  // One bus cycle: EN high for a clock, then the falling edge.
  // Ends on the negedge after the strobe clock edge.
  task automatic bus_op(input logic rs, input logic rw,
                        input logic [7:0] d);
    logic bb;
    int s;
    @(negedge clk);
    last_st = {(cyc < busy_end), m_ac};
    RS = rs; RW = rw; data = {8'($urandom), d}; EN = 1;
    @(negedge clk);
    last_rd = data_out;
    bb = (cyc < busy_end);
    s = cyc + 1;
    EN = 0;
    @(posedge clk);
    model_apply(rs, rw, d, bb, s);
    @(negedge clk);
  endtask

  task automatic wait_idle();
    while (cyc < busy_end) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1; EN = 0; RW = 0; RS = 0; data = 0; rd_addr = 0;
    repeat (3) @(negedge clk);
    model_reset();
    tests++;
    if (ac !== 7'h00 || busy !== 1'b0 || entry_inc !== 1'b1) begin
      $display("FAIL reset_core: ac=%h busy=%b inc=%b want 00 0 1",
               ac, busy, entry_inc);
      fails++;
    end
    tests++;
    if ({display_on, cursor_on, blink_on, two_line, entry_shift,
         bad_cmd, overrun, data_out} !== 15'h0) begin
      $display("FAIL reset_flags: got %b%b%b%b%b%b%b dout=%h want 0",
               display_on, cursor_on, blink_on, two_line,
               entry_shift, bad_cmd, overrun, data_out);
      fails++;
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i); #1;
      tests++;
      if (rd_char !== 8'h20) begin
        $display("FAIL reset_char[%0d]: got %h want 20", i, rd_char);
        fails++;
      end
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_clear_text();
    logic [7:0] seq [11];
    logic [39:0] txt;
    seq = '{8'h38, 8'h0E, 8'h01, 8'h02, 8'h06,
            8'h43, 8'h4C, 8'h45, 8'h41, 8'h52, 8'h00};
    txt = "CLEAR";
    for (int i = 0; i < 10; i++) begin
      bus_op(i >= 5, 1'b0, seq[i]);
      repeat (CC + 5) @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      rd_addr = 5'(i); #1;
      tests++;
      if (rd_char !== txt[8*(4-i) +: 8]) begin
        $display("FAIL text_char[%0d]: got %h want %h",
                 i, rd_char, txt[8*(4-i) +: 8]);
        fails++;
      end
    end
    tests++;
    if (ac !== 7'h05) begin
      $display("FAIL text_ac: got %h want 05", ac); fails++;
    end
    tests++;
    if ({two_line, display_on, cursor_on, blink_on, bad_cmd, overrun}
        !== 6'b111000) begin
      $display("FAIL text_flags: got %b%b%b%b%b%b want 111000",
               two_line, display_on, cursor_on, blink_on,
               bad_cmd, overrun);
      fails++;
    end
  endtask

  task automatic test_clear_busy();
    int n;
    int badc;
    bus_op(1'b0, 1'b0, 8'h01);
    n = 0;
    while (busy === 1'b1 && n < CC + 10) begin
      if (n == 33) begin
        badc = 0;
        for (int i = 0; i < 32; i++) begin
          rd_addr = 5'(i); #1;
          if (rd_char !== 8'h20) badc++;
        end
        tests++;
        if (badc != 0) begin
          $display("FAIL clear_fill: %0d cells not 20, want 0", badc);
          fails++;
        end
      end
      n++;
      @(negedge clk);
    end
    tests++;
    if (n != CC) begin
      $display("FAIL clear_busy_len: got %0d want %0d", n, CC);
      fails++;
    end
    tests++;
    if (ac !== 7'h00) begin
      $display("FAIL clear_ac: got %h want 00", ac); fails++;
    end
  endtask

  task automatic test_wrap();
    wait_idle(); bus_op(0, 0, 8'h8F);
    wait_idle(); bus_op(1, 0, 8'h41);
    wait_idle(); bus_op(1, 0, 8'h42);
    rd_addr = 15; #1;
    tests++;
    if (rd_char !== 8'h41) begin
      $display("FAIL wrap_c15: got %h want 41", rd_char); fails++;
    end
    rd_addr = 16; #1;
    tests++;
    if (rd_char !== 8'h42) begin
      $display("FAIL wrap_c16: got %h want 42", rd_char); fails++;
    end
    tests++;
    if (ac !== 7'h41) begin
      $display("FAIL wrap_ac: got %h want 41", ac); fails++;
    end
    wait_idle(); bus_op(0, 0, 8'h04);
    wait_idle(); bus_op(1, 0, 8'h43);
    rd_addr = 17; #1;
    tests++;
    if (rd_char !== 8'h43 || ac !== 7'h40) begin
      $display("FAIL wrap_dec: c17=%h ac=%h want 43 40", rd_char, ac);
      fails++;
    end
  endtask

  task automatic test_overrun();
    wait_idle(); bus_op(0, 0, 8'h06);
    wait_idle(); bus_op(1, 0, 8'h58);
    bus_op(1, 0, 8'h59);
    bus_op(0, 1, 8'h00);
    tests++;
    if (last_rd[7] !== 1'b1 || last_rd[6:0] !== m_ac) begin
      $display("FAIL status_busy: got %h want %h", last_rd, {1'b1, m_ac});
      fails++;
    end
    tests++;
    if (last_rd !== last_st) begin
      $display("FAIL status_model: got %h want %h", last_rd, last_st);
      fails++;
    end
    tests++;
    if (data_out !== 8'h00) begin
      $display("FAIL dout_idle: got %h want 00", data_out); fails++;
    end
    rd_addr = 17; #1;
    tests++;
    if (rd_char !== 8'h43 || overrun !== 1'b1 || ac !== 7'h41) begin
      $display("FAIL overrun: c17=%h ov=%b ac=%h want 43 1 41",
               rd_char, overrun, ac);
      fails++;
    end
  endtask

  task automatic test_bad_cmd();
    wait_idle(); bus_op(0, 0, 8'h90);
    tests++;
    if (bad_cmd !== 1'b1 || ac !== m_ac) begin
      $display("FAIL bad_ddram: bad=%b ac=%h want 1 %h", bad_cmd, ac, m_ac);
      fails++;
    end
    wait_idle(); bus_op(0, 0, 8'h40);
    tests++;
    if (bad_cmd !== 1'b1 || ac !== 7'h41) begin
      $display("FAIL bad_cgram: bad=%b ac=%h want 1 41", bad_cmd, ac);
      fails++;
    end
    wait_idle(); bus_op(0, 0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (busy !== 1'b0) begin
        $display("FAIL nop_busy: got %b want 0", busy); fails++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_data_read();
    logic [7:0] e;
    wait_idle(); bus_op(0, 0, 8'h8F);
    wait_idle();
    for (int i = 0; i < 3; i++) begin
      e = m_cells[pos_of(m_ac)];
      bus_op(1, 1, 8'h00);
      tests++;
      if (last_rd !== e || ac !== m_ac || busy !== (cyc < busy_end)) begin
        $display("FAIL data_read%0d: rd=%h ac=%h busy=%b want %h %h %b",
                 i, last_rd, ac, busy, e, m_ac, (cyc < busy_end));
        fails++;
      end
    end
  endtask

  task automatic test_random();
    int sel;
    int p;
    logic [7:0] d;
    logic [7:0] e;
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 5) != 0) wait_idle();
      sel = $urandom_range(0, 8);
      e = m_cells[pos_of(m_ac)];
      case (sel)
        0, 1, 2: bus_op(1, 0, 8'($urandom_range(33, 126)));
        3: begin
          p = $urandom_range(0, 31);
          bus_op(0, 0, 8'h80 | 8'(addr_of(p)));
        end
        4: bus_op(0, 0, 8'h04 | 8'($urandom_range(0, 3)));
        5: bus_op(0, 0, 8'h10 | 8'($urandom_range(0, 15)));
        6: bus_op(0, 0, 8'h08 | 8'($urandom_range(0, 7)));
        7: bus_op(0, 0, 8'h20 | 8'($urandom_range(0, 31)));
        default: begin
          bus_op(1, 1, 8'h00);
          tests++;
          if (last_rd !== e) begin
            $display("FAIL rnd_read%0d: got %h want %h", k, last_rd, e);
            fails++;
          end
        end
      endcase
      d = 8'(k);
      tests++;
      if (ac !== m_ac || busy !== (cyc < busy_end) ||
          overrun !== m_over) begin
        $display("FAIL rnd_state%0d: ac=%h busy=%b ov=%b want %h %b %b",
                 d, ac, busy, overrun, m_ac, (cyc < busy_end), m_over);
        fails++;
      end
      p = $urandom_range(0, 31);
      rd_addr = 5'(p); #1;
      tests++;
      if (rd_char !== m_cells[p]) begin
        $display("FAIL rnd_char%0d[%0d]: got %h want %h",
                 k, p, rd_char, m_cells[p]);
        fails++;
      end
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i); #1;
      tests++;
      if (rd_char !== m_cells[i]) begin
        $display("FAIL rnd_final[%0d]: got %h want %h",
                 i, rd_char, m_cells[i]);
        fails++;
      end
    end
    tests++;
    if ({display_on, cursor_on, blink_on, two_line, entry_inc,
         entry_shift, bad_cmd} !==
        {m_disp, m_cur, m_blink, m_two, m_inc, m_shift, m_bad}) begin
      $display("FAIL rnd_flags: got %b%b%b%b%b%b%b want %b%b%b%b%b%b%b",
               display_on, cursor_on, blink_on, two_line, entry_inc,
               entry_shift, bad_cmd, m_disp, m_cur, m_blink, m_two,
               m_inc, m_shift, m_bad);
      fails++;
    end
  endtask

  task automatic test_reset_fill();
    int badc;
    wait_idle(); bus_op(0, 0, 8'h06);
    wait_idle(); bus_op(0, 0, 8'hC4);
    wait_idle(); bus_op(1, 0, 8'h48);
    wait_idle(); bus_op(1, 0, 8'h49);
    wait_idle(); bus_op(0, 0, 8'h01);
    repeat (10) @(negedge clk);
    rst = 1; #1;
    model_reset();
    tests++;
    if (ac !== 7'h00 || busy !== 1'b0 || entry_inc !== 1'b1 ||
        data_out !== 8'h00) begin
      $display("FAIL rstfill_core: ac=%h busy=%b inc=%b dout=%h",
               ac, busy, entry_inc, data_out);
      fails++;
    end
    tests++;
    if ({display_on, cursor_on, blink_on, two_line, entry_shift,
         bad_cmd, overrun} !== 7'h0) begin
      $display("FAIL rstfill_flags: got %b%b%b%b%b%b%b want 0",
               display_on, cursor_on, blink_on, two_line,
               entry_shift, bad_cmd, overrun);
      fails++;
    end
    badc = 0;
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i); #1;
      if (rd_char !== 8'h20) badc++;
    end
    tests++;
    if (badc != 0) begin
      $display("FAIL rstfill_chars: %0d cells not 20, want 0", badc);
      fails++;
    end
    @(negedge clk);
    rst = 0;
    bus_op(1, 0, 8'h5A);
    rd_addr = 0; #1;
    tests++;
    if (rd_char !== 8'h5A || ac !== 7'h01 || busy !== 1'b1 ||
        overrun !== 1'b0) begin
      $display("FAIL rstfill_next: c0=%h ac=%h busy=%b ov=%b",
               rd_char, ac, busy, overrun);
      fails++;
    end
  endtask

  initial begin
    test_reset();
    test_clear_text();
    test_clear_busy();
    test_wrap();
    test_overrun();
    test_bad_cmd();
    test_data_read();
    test_random();
    test_reset_fill();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
